// File: rtl/sensor_interval_timer.sv
// -----------------------------------------------------------------------------
// sensor_interval_timer
//
// Measures the time in milliseconds between a train passing track sensor S1
// and track sensor S2, and hands the result to the arrival predictor as a
// TIME_W-bit interval word (time_ms -> predictor time_in).
//
// Each raw sensor pin is synchronised (2 flops), debounced (DEBOUNCE_CYC
// consecutive high samples) and edge-detected into a 1-cycle event.
// A prescaler turns clk into a 1 ms tick. The FSM then runs one measurement
// per S1 -> S2 pass.
//
// Parameters
//   TICK_DIV      clk cycles per 1 ms tick
//   DEBOUNCE_CYC  consecutive synchronised-high cycles needed to accept a sensor
//   TIME_W        width of time_ms; all-ones is the saturation value
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   sensor_s1   raw S1 pin (asynchronous, bouncy, high = train present)
//   sensor_s2   raw S2 pin (asynchronous, bouncy, high = train present)
//   time_ms     last measured interval in ms, never 0 after a measurement
//   time_valid  1-cycle pulse: time_ms was updated this cycle
//   timeout     1-cycle pulse: S2 not seen before the ms counter saturated
//   busy        high while a measurement is in progress
// -----------------------------------------------------------------------------
module sensor_interval_timer #(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int TIME_W       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sensor_s1,
  input  logic              sensor_s2,
  output logic [TIME_W-1:0] time_ms,
  output logic              time_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_CYC);
  localparam logic [TIME_W-1:0]  MS_MAX     = {TIME_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Input conditioning: index 0 = S1, index 1 = S2
  // ---------------------------------------------------------------------------
  logic [1:0] raw_pin;
  logic [1:0] sensor_evt;

  assign raw_pin = {sensor_s2, sensor_s1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
      logic            meta_reg;
      logic            sync_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic [DB_W-1:0] db_cnt_next;
      logic            level_reg;
      logic            evt_reg;
      logic            level_next;

      // Count consecutive synchronised-high samples, holding at DB_MAX so a
      // long train never wraps the counter back below the threshold.
      always_comb begin
        db_cnt_next = '0;
        if (sync_reg) begin
          if (db_cnt_reg == DB_MAX) begin
            db_cnt_next = DB_MAX;
          end else begin
            db_cnt_next = db_cnt_reg + DB_W'(1);
          end
        end
      end

      assign level_next = (db_cnt_next == DB_MAX);

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg   <= 1'b0;
          sync_reg   <= 1'b0;
          db_cnt_reg <= '0;
          level_reg  <= 1'b0;
          evt_reg    <= 1'b0;
        end else begin
          meta_reg   <= raw_pin[gi];
          sync_reg   <= meta_reg;
          db_cnt_reg <= db_cnt_next;
          level_reg  <= level_next;
          // Rising edge of the debounced level only: one event per train.
          evt_reg    <= level_next && !level_reg;
        end
      end

      assign sensor_evt[gi] = evt_reg;
    end
  endgenerate

  logic evt_s1;
  logic evt_s2;

  assign evt_s1 = sensor_evt[0];
  assign evt_s2 = sensor_evt[1];

  // ---------------------------------------------------------------------------
  // Timebase and measurement FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TIMING,
    ST_DONE,
    ST_TOUT
  } state_t;

  state_t              state_reg;
  logic [PRESC_W-1:0]  presc_reg;
  logic [TIME_W-1:0]   ms_cnt_reg;

  logic                ms_tick;
  logic                ms_sat;
  logic [TIME_W-1:0]   ms_cnt_next;
  logic [TIME_W-1:0]   result_next;

  assign ms_tick = (presc_reg == PRESC_LAST);

  // A tick arriving while the counter already holds the all-ones value would
  // wrap it; that situation is reported as a timeout instead.
  assign ms_sat = ms_tick && (ms_cnt_reg == MS_MAX);

  // The tick landing in the same cycle as S2 still counts toward the result.
  always_comb begin
    ms_cnt_next = ms_cnt_reg;
    if (ms_tick && !ms_sat) begin
      ms_cnt_next = ms_cnt_reg + TIME_W'(1);
    end
  end

  // Floor of 1 ms: the predictor divides by this value.
  always_comb begin
    result_next = ms_cnt_next;
    if (ms_cnt_next == '0) begin
      result_next = TIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      presc_reg  <= '0;
      ms_cnt_reg <= '0;
      time_ms    <= '0;
      time_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      timeout    <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          presc_reg  <= '0;
          ms_cnt_reg <= '0;
          // S2 alone is ignored here; with both events S1 starts a run.
          if (evt_s1) begin
            state_reg <= ST_TIMING;
            busy      <= 1'b1;
          end
        end

        ST_TIMING: begin
          presc_reg  <= ms_tick ? '0 : presc_reg + PRESC_W'(1);
          ms_cnt_reg <= ms_cnt_next;

          if (ms_sat) begin
            state_reg <= ST_TOUT;
            timeout   <= 1'b1;
            busy      <= 1'b0;
          end else if (evt_s2) begin
            // S2 wins over a simultaneous S1: the measurement completes.
            // Outputs are registered on entry so the pulse lands in DONE.
            state_reg  <= ST_DONE;
            time_ms    <= result_next;
            time_valid <= 1'b1;
            busy       <= 1'b0;
          end else if (evt_s1) begin
            // A fresh S1 restarts the interval from zero.
            presc_reg  <= '0;
            ms_cnt_reg <= '0;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        ST_TOUT: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_interval_timer.sv
module tb_sensor_interval_timer;

  localparam int TICK  = 10;
  localparam int DEB   = 2;
  // Narrower counter than the production width keeps the saturation run short.
  localparam int TW    = 12;
  localparam int MAXMS = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sensor_s1;
  logic          sensor_s2;
  logic [TW-1:0] time_ms;
  logic          time_valid;
  logic          timeout;
  logic          busy;

  always #5 clk = ~clk;

  sensor_interval_timer #(
    .TICK_DIV    (TICK),
    .DEBOUNCE_CYC(DEB),
    .TIME_W      (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_s1 (sensor_s1),
    .sensor_s2 (sensor_s2),
    .time_ms   (time_ms),
    .time_valid(time_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: sensors accepted after DEB consecutive high samples and
  // reported two cycles later; interval = elapsed timing cycles / TICK.
  // ---------------------------------------------------------------------------
  int        run1, run2;
  logic [2:0] d1, d2;
  bit        active, dead, checking;
  int        k;
  logic [TW-1:0] exp_time;
  bit        exp_valid, exp_tout, exp_busy;

  always @(posedge clk) begin
    bit e1, e2;
    cyc++;
    if (rst) begin
      run1 = 0; run2 = 0; d1 = '0; d2 = '0;
      active = 0; dead = 0; k = 0;
      exp_time = '0; exp_valid = 0; exp_tout = 0; exp_busy = 0;
      checking = 1;
    end else begin
      e1 = d1[2];
      e2 = d2[2];
      run1 = sensor_s1 ? run1 + 1 : 0;
      run2 = sensor_s2 ? run2 + 1 : 0;
      d1 = {d1[1:0], (run1 == DEB)};
      d2 = {d2[1:0], (run2 == DEB)};
      exp_valid = 0;
      exp_tout  = 0;
      if (dead) begin
        dead = 0;
      end else if (!active) begin
        if (e1) begin
          active = 1;
          k = 0;
        end
      end else begin
        k++;
        if (k == (MAXMS + 1) * TICK) begin
          exp_tout = 1; active = 0; dead = 1;
        end else if (e2) begin
          exp_valid = 1; active = 0; dead = 1;
          exp_time = (k / TICK == 0) ? TW'(1) : TW'(k / TICK);
        end else if (e1) begin
          k = 0;
        end
      end
      exp_busy = active;
    end
  end

  // Per-cycle compare plus pulse counters used by the literal checks.
  int valid_cnt = 0;
  int tout_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("time_valid", 32'(time_valid), 32'(exp_valid));
      chk("timeout", 32'(timeout), 32'(exp_tout));
      chk("time_ms", 32'(time_ms), 32'(exp_time));
      if (time_valid) valid_cnt++;
      if (timeout) tout_cnt++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    sensor_s1 = 1'b0;
    sensor_s2 = 1'b0;
    hold(3);
    rst = 1'b0;
    chk("rst_time_ms", 32'(time_ms), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(time_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    hold(5);

    // S2 with no S1 first: ignored
    sensor_s2 = 1'b1; hold(5); sensor_s2 = 1'b0; hold(20);
    chk("s2_only_valid_cnt", 32'(valid_cnt), 0);
    chk("s2_only_time_ms", 32'(time_ms), 0);
    chk("s2_only_busy", 32'(busy), 0);
    $display("txn s2_only: time_ms=%0d valid_cnt=%0d", time_ms, valid_cnt);

    // S1, S2 rising 250 clk later -> 25 ms
    sensor_s1 = 1'b1; hold(5); sensor_s1 = 1'b0; hold(245);
    sensor_s2 = 1'b1; hold(5); sensor_s2 = 1'b0; hold(20);
    chk("basic_time_ms", 32'(time_ms), 25);
    chk("basic_valid_cnt", 32'(valid_cnt), 1);
    chk("basic_busy", 32'(busy), 0);
    $display("txn basic: time_ms=%0d", time_ms);

    // S2 only 4 clk after S1 -> floor of 1 ms
    sensor_s1 = 1'b1; hold(4); sensor_s1 = 1'b0;
    sensor_s2 = 1'b1; hold(5); sensor_s2 = 1'b0; hold(20);
    chk("floor_time_ms", 32'(time_ms), 1);
    chk("floor_valid_cnt", 32'(valid_cnt), 2);
    $display("txn floor: time_ms=%0d", time_ms);

    // S1, S1 again 100 clk later, S2 300 clk after that -> 30 ms
    sensor_s1 = 1'b1; hold(5); sensor_s1 = 1'b0; hold(95);
    sensor_s1 = 1'b1; hold(5); sensor_s1 = 1'b0; hold(295);
    sensor_s2 = 1'b1; hold(5); sensor_s2 = 1'b0; hold(20);
    chk("restart_time_ms", 32'(time_ms), 30);
    chk("restart_valid_cnt", 32'(valid_cnt), 3);
    $display("txn restart: time_ms=%0d", time_ms);

    // S1 with no S2 until the counter saturates -> one timeout pulse
    sensor_s1 = 1'b1; hold(5); sensor_s1 = 1'b0;
    hold((MAXMS + 1) * TICK + 30);
    chk("tout_cnt", 32'(tout_cnt), 1);
    chk("tout_time_ms_kept", 32'(time_ms), 30);
    chk("tout_valid_cnt", 32'(valid_cnt), 3);
    chk("tout_busy", 32'(busy), 0);
    $display("txn timeout: tout_cnt=%0d time_ms=%0d", tout_cnt, time_ms);

    // 1-clk glitch on S1: rejected
    sensor_s1 = 1'b1; hold(1); sensor_s1 = 1'b0; hold(5);
    chk("glitch_busy", 32'(busy), 0);
    hold(10);
    $display("txn glitch: busy=%0d", busy);

    // Reset in the middle of a measurement: aborted without a pulse
    sensor_s1 = 1'b1; hold(5); sensor_s1 = 1'b0; hold(50);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1; hold(2); rst = 1'b0; hold(1);
    chk("mid_rst_time_ms", 32'(time_ms), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    hold(30);
    chk("mid_rst_valid_cnt", 32'(valid_cnt), 3);
    chk("mid_rst_tout_cnt", 32'(tout_cnt), 1);
    $display("txn mid_reset: time_ms=%0d busy=%0d", time_ms, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
